round_judge: RTL and testbench

- Downstream of the player Morse accumulator; consumes its 10-bit packed code (5 symbols x 2 bits: 00 none, 01 dot, 11 line).
- Runs one game of MAX_ROUNDS rounds: latches a target code, gives the player TIMEOUT cycles to submit, and compares the submitted code with the target.
- Keeps score, requests an accumulator clear between rounds, and flags game over.

---
 rtl/round_judge.sv | 153 +++++++++++++++
 tb/tb_round_judge.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_judge.sv
// Judges one Morse guessing game: latches a target, times the player's guess,
// scores the comparison and asks the accumulator to clear between rounds.
module round_judge #(
    parameter int unsigned CODE_W     = 10,
    parameter int unsigned TIMEOUT    = 50000000,
    parameter int unsigned MAX_ROUNDS = 8,
    parameter int unsigned SCORE_W    = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [CODE_W-1:0]  target_code,
    input  logic               target_valid,
    input  logic [CODE_W-1:0]  p1_code,
    input  logic               submit,
    output logic               code_clear,
    output logic               match,
    output logic               miss,
    output logic               timed_out,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] round,
    output logic               busy,
    output logic               game_over
);

    localparam int unsigned        TIMER_W    = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] CNT_MAX    = '1;
    localparam logic [SCORE_W-1:0] ROUND_LAST = SCORE_W'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TARGET,
        ST_WAIT_GUESS,
        ST_JUDGE,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic [TIMER_W-1:0]  r_timer;
    logic [CODE_W-1:0]   r_target;
    logic [CODE_W-1:0]   r_guess;
    logic [SCORE_W-1:0]  r_score;
    logic [SCORE_W-1:0]  r_round;
    logic                r_code_clear;
    logic                r_match;
    logic                r_miss;
    logic                r_timed_out;
    logic                r_busy;
    logic                r_game_over;

    logic [SCORE_W-1:0]  w_round_inc;
    logic [SCORE_W-1:0]  w_score_inc;
    logic                w_last_round;
    logic                w_hit;

    // Saturating increments; the round just finishing decides whether the game ends.
    assign w_round_inc  = (r_round == CNT_MAX) ? r_round : r_round + SCORE_W'(1);
    assign w_score_inc  = (r_score == CNT_MAX) ? r_score : r_score + SCORE_W'(1);
    assign w_last_round = (w_round_inc == ROUND_LAST);
    assign w_hit        = (r_guess == r_target);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_target     <= '0;
            r_guess      <= '0;
            r_score      <= '0;
            r_round      <= '0;
            r_code_clear <= 1'b0;
            r_match      <= 1'b0;
            r_miss       <= 1'b0;
            r_timed_out  <= 1'b0;
            r_busy       <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_code_clear <= 1'b0;
            r_match      <= 1'b0;
            r_miss       <= 1'b0;
            r_timed_out  <= 1'b0;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_WAIT_TARGET;
                        r_score     <= '0;
                        r_round     <= '0;
                        r_busy      <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end

                // An all-zero code carries no symbols, so it cannot be a target.
                ST_WAIT_TARGET: begin
                    if (target_valid && (target_code != '0)) begin
                        r_target     <= target_code;
                        r_timer      <= TIMER_LOAD;
                        r_code_clear <= 1'b1;
                        r_state      <= ST_WAIT_GUESS;
                    end
                end

                // A submit on the final timer cycle still counts as a guess.
                ST_WAIT_GUESS: begin
                    r_timer <= r_timer - TIMER_W'(1);
                    if (submit) begin
                        r_guess <= p1_code;
                        r_state <= ST_JUDGE;
                    end else if (r_timer == '0) begin
                        r_miss       <= 1'b1;
                        r_timed_out  <= 1'b1;
                        r_code_clear <= 1'b1;
                        r_round      <= w_round_inc;
                        r_state      <= w_last_round ? ST_DONE : ST_WAIT_TARGET;
                        r_busy       <= !w_last_round;
                        r_game_over  <= w_last_round;
                    end
                end

                ST_JUDGE: begin
                    if (w_hit) begin
                        r_match <= 1'b1;
                        r_score <= w_score_inc;
                    end else begin
                        r_miss <= 1'b1;
                    end
                    r_code_clear <= 1'b1;
                    r_round      <= w_round_inc;
                    r_state      <= w_last_round ? ST_DONE : ST_WAIT_TARGET;
                    r_busy       <= !w_last_round;
                    r_game_over  <= w_last_round;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign code_clear = r_code_clear;
    assign match      = r_match;
    assign miss       = r_miss;
    assign timed_out  = r_timed_out;
    assign score      = r_score;
    assign round      = r_round;
    assign busy       = r_busy;
    assign game_over  = r_game_over;

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: directed vector table, hand sequences for timing corners,
// and randomized games checked against a round-level outcome model.
module tb_round_judge;

    localparam int unsigned CODE_W     = 10;
    localparam int unsigned TIMEOUT    = 20;
    localparam int unsigned MAX_ROUNDS = 3;
    localparam int unsigned SCORE_W    = 4;
    localparam int          CNT_MAX    = (1 << SCORE_W) - 1;

    logic               clock = 1'b0;
    logic               resetn;
    logic               start;
    logic [CODE_W-1:0]  target_code;
    logic               target_valid;
    logic [CODE_W-1:0]  p1_code;
    logic               submit;
    logic               code_clear;
    logic               match;
    logic               miss;
    logic               timed_out;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] round;
    logic               busy;
    logic               game_over;

    round_judge #(
        .CODE_W    (CODE_W),
        .TIMEOUT   (TIMEOUT),
        .MAX_ROUNDS(MAX_ROUNDS),
        .SCORE_W   (SCORE_W)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .target_code (target_code),
        .target_valid(target_valid),
        .p1_code     (p1_code),
        .submit      (submit),
        .code_clear  (code_clear),
        .match       (match),
        .miss        (miss),
        .timed_out   (timed_out),
        .score       (score),
        .round       (round),
        .busy        (busy),
        .game_over   (game_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic              start;
        logic              tv;
        logic [CODE_W-1:0] tc;
        logic [CODE_W-1:0] p1;
        logic              sub;
        logic              cc;
        logic              m;
        logic              ms;
        logic              to;
        int                sc;
        int                rd;
        logic              bz;
        logic              go;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input int st, input int tv, input int tc, input int p1,
                                input int sub, input int cc, input int m, input int ms,
                                input int to, input int sc, input int rd, input int bz,
                                input int go);
        vec_t v;
        v.start = st[0];
        v.tv    = tv[0];
        v.tc    = CODE_W'(tc);
        v.p1    = CODE_W'(p1);
        v.sub   = sub[0];
        v.cc    = cc[0];
        v.m     = m[0];
        v.ms    = ms[0];
        v.to    = to[0];
        v.sc    = sc;
        v.rd    = rd;
        v.bz    = bz[0];
        v.go    = go[0];
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, ".code_clear"}, int'(code_clear), int'(v.cc));
        check({tag, ".match"},      int'(match),      int'(v.m));
        check({tag, ".miss"},       int'(miss),       int'(v.ms));
        check({tag, ".timed_out"},  int'(timed_out),  int'(v.to));
        check({tag, ".score"},      int'(score),      v.sc);
        check({tag, ".round"},      int'(round),      v.rd);
        check({tag, ".busy"},       int'(busy),       int'(v.bz));
        check({tag, ".game_over"},  int'(game_over),  int'(v.go));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        start        = 1'b0;
        target_valid = 1'b0;
        target_code  = '0;
        submit       = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        start        = v.start;
        target_valid = v.tv;
        target_code  = v.tc;
        p1_code      = v.p1;
        submit       = v.sub;
    endtask

    function automatic int sat_inc(input int x);
        return (x >= CNT_MAX) ? CNT_MAX : x + 1;
    endfunction

    vec_t vecs[16];
    vec_t zero_v;

    initial begin
        int exp_sc;
        int exp_rd;
        int cnt;
        int n;
        bit quiet;
        bit seen;
        bit exp_hit;
        logic [CODE_W-1:0] tgt;
        logic [CODE_W-1:0] guess;

        zero_v = mk(0,0,0,0,0, 0,0,0,0,0,0,0,0);

        // One full game: correct, wrong, correct, with ignored inputs sprinkled in.
        vecs[0]  = mk(0,1,7,7,1,   0,0,0,0, 0,0, 0,0);
        vecs[1]  = mk(1,0,0,0,0,   0,0,0,0, 0,0, 1,0);
        vecs[2]  = mk(0,1,0,0,1,   0,0,0,0, 0,0, 1,0);
        vecs[3]  = mk(0,1,7,0,0,   1,0,0,0, 0,0, 1,0);
        vecs[4]  = mk(0,0,0,7,1,   0,0,0,0, 0,0, 1,0);
        vecs[5]  = mk(0,0,0,0,0,   1,1,0,0, 1,1, 1,0);
        vecs[6]  = mk(0,1,0,0,0,   0,0,0,0, 1,1, 1,0);
        vecs[7]  = mk(0,1,13,0,0,  1,0,0,0, 1,1, 1,0);
        vecs[8]  = mk(0,1,7,7,1,   0,0,0,0, 1,1, 1,0);
        vecs[9]  = mk(0,0,0,0,0,   1,0,1,0, 1,2, 1,0);
        vecs[10] = mk(1,0,0,0,0,   0,0,0,0, 1,2, 1,0);
        vecs[11] = mk(0,1,7,0,0,   1,0,0,0, 1,2, 1,0);
        vecs[12] = mk(1,0,0,7,1,   0,0,0,0, 1,2, 1,0);
        vecs[13] = mk(0,0,0,0,0,   1,1,0,0, 2,3, 0,1);
        vecs[14] = mk(0,1,7,7,1,   0,0,0,0, 2,3, 0,1);
        vecs[15] = mk(1,0,0,0,0,   0,0,0,0, 0,0, 1,0);

        resetn  = 1'b0;
        p1_code = '0;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        check_outs("reset_hold", zero_v);
        resetn = 1'b1;
        step();
        check_outs("reset_release", zero_v);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i]);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i]);
        end
        idle_inputs();

        // Timeout: miss/timed_out exactly TIMEOUT cycles after the target latch.
        target_valid = 1'b1;
        target_code  = 10'b0000001111;
        step();
        check("timeout.latch_clear", int'(code_clear), 1);
        idle_inputs();
        seen = 1'b0;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            step();
            if (miss || match || timed_out || code_clear) seen = 1'b1;
        end
        check("timeout.early_pulse", int'(seen), 0);
        step();
        check_outs("timeout", mk(0,0,0,0,0, 1,0,1,1, 0,1, 1,0));
        step();
        check_outs("timeout_after", mk(0,0,0,0,0, 0,0,0,0, 0,1, 1,0));

        // Submit on the very cycle the timer expires: judged, not timed out.
        target_valid = 1'b1;
        target_code  = 10'd7;
        step();
        check("collide.latch_clear", int'(code_clear), 1);
        idle_inputs();
        repeat (TIMEOUT - 1) step();
        p1_code = 10'd7;
        submit  = 1'b1;
        step();
        idle_inputs();
        check_outs("collide_submit", mk(0,0,0,0,0, 0,0,0,0, 0,1, 1,0));
        step();
        check_outs("collide_judge", mk(0,0,0,0,0, 1,1,0,0, 1,2, 1,0));

        // Mid-game asynchronous reset clears everything without a pulse.
        target_valid = 1'b1;
        target_code  = 10'd5;
        step();
        idle_inputs();
        step();
        #2;
        resetn = 1'b0;
        #1;
        check_outs("async_reset", zero_v);
        step();
        step();
        check_outs("reset_held", zero_v);
        resetn       = 1'b1;
        submit       = 1'b1;
        target_valid = 1'b1;
        target_code  = 10'd7;
        step();
        check_outs("post_reset_idle", zero_v);
        idle_inputs();

        // Randomized games against a round-level outcome model.
        for (int g = 0; g < 15; g++) begin
            idle_inputs();
            start = 1'b1;
            step();
            start = 1'b0;
            exp_sc = 0;
            exp_rd = 0;
            check("rnd.start_busy", int'(busy), 1);
            check("rnd.start_score", int'(score), 0);
            check("rnd.start_round", int'(round), 0);
            for (int r = 0; r < int'(MAX_ROUNDS); r++) begin
                quiet = 1'b1;
                n = int'($urandom_range(0, 3));
                for (int k = 0; k < n; k++) begin
                    target_valid = 1'($urandom);
                    target_code  = '0;
                    submit       = 1'($urandom);
                    start        = 1'($urandom);
                    p1_code      = CODE_W'($urandom);
                    step();
                    if (code_clear || match || miss || timed_out || !busy || int'(round) != exp_rd)
                        quiet = 1'b0;
                end
                check("rnd.wait_target_quiet", int'(quiet), 1);
                idle_inputs();
                tgt          = CODE_W'($urandom_range(1, (1 << CODE_W) - 1));
                target_valid = 1'b1;
                target_code  = tgt;
                step();
                check("rnd.latch_clear", int'(code_clear), 1);
                idle_inputs();
                if ($urandom_range(0, 3) == 0) begin
                    cnt  = 0;
                    seen = 1'b0;
                    while (!seen && cnt < 2 * int'(TIMEOUT)) begin
                        target_valid = 1'($urandom);
                        target_code  = CODE_W'($urandom);
                        start        = 1'($urandom);
                        p1_code      = CODE_W'($urandom);
                        step();
                        cnt++;
                        if (match || miss) seen = 1'b1;
                    end
                    idle_inputs();
                    check("rnd.timeout_latency", cnt, int'(TIMEOUT));
                    check("rnd.timeout_miss", int'(miss), 1);
                    check("rnd.timeout_flag", int'(timed_out), 1);
                    check("rnd.timeout_match", int'(match), 0);
                    check("rnd.timeout_clear", int'(code_clear), 1);
                    exp_rd = sat_inc(exp_rd);
                end else begin
                    n = int'($urandom_range(0, TIMEOUT - 1));
                    quiet = 1'b1;
                    for (int k = 0; k < n; k++) begin
                        target_valid = 1'($urandom);
                        target_code  = CODE_W'($urandom);
                        start        = 1'($urandom);
                        p1_code      = CODE_W'($urandom);
                        step();
                        if (match || miss || timed_out || code_clear) quiet = 1'b0;
                    end
                    check("rnd.guess_window_quiet", int'(quiet), 1);
                    idle_inputs();
                    guess   = ($urandom_range(0, 1) == 1) ? tgt : CODE_W'($urandom);
                    p1_code = guess;
                    submit  = 1'b1;
                    step();
                    idle_inputs();
                    p1_code = CODE_W'($urandom);
                    check("rnd.submit_no_pulse", int'(match || miss || code_clear), 0);
                    step();
                    exp_hit = (guess == tgt);
                    check("rnd.judge_match", int'(match), int'(exp_hit));
                    check("rnd.judge_miss", int'(miss), int'(!exp_hit));
                    check("rnd.judge_timed_out", int'(timed_out), 0);
                    check("rnd.judge_clear", int'(code_clear), 1);
                    if (exp_hit) exp_sc = sat_inc(exp_sc);
                    exp_rd = sat_inc(exp_rd);
                end
                check("rnd.score", int'(score), exp_sc);
                check("rnd.round", int'(round), exp_rd);
                check("rnd.game_over", int'(game_over), int'(exp_rd == int'(MAX_ROUNDS)));
                check("rnd.busy", int'(busy), int'(exp_rd != int'(MAX_ROUNDS)));
            end
            quiet = 1'b1;
            repeat (3) begin
                target_valid = 1'($urandom);
                target_code  = CODE_W'($urandom);
                submit       = 1'($urandom);
                step();
                if (!game_over || busy || match || miss || code_clear || int'(score) != exp_sc)
                    quiet = 1'b0;
            end
            idle_inputs();
            check("rnd.done_holds", int'(quiet), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
